alu_exec: RTL
=============

Name: alu_exec

Overview:
- Registered execute unit on the consumer end of the 3-bit ALU control interface driven by the ALU decoder.
- Accepts an operation with operands through a valid/ready handshake and computes it.
- Returns result, zero and overflow flags through a second valid/ready handshake.
- Logic ops complete in 1 cycle. Shifts run iteratively, 1 bit per cycle, for the multicycle datapath variant.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, $clog2(WIDTH), shift-amount width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept request
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B; shift amount = src_b[SHW-1:0]
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with result
- overflow  output  1  signed overflow for add/sub; 0 for all other ops

Behaviour:
- Clock/reset (already decided): one clock, clk. Reset is asynchronous and active-low, reset_n.
- While reset_n is low:
  - state=IDLE, out_valid=0, result=0, zero=0, overflow=0, shift counter=0.
  - in_ready is 0 during reset, then combinational as defined below.
- States:
  - IDLE: no operation in flight.
  - SHIFT: shift iterating.
  - HOLD: result valid, waiting for the consumer.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Back-to-back issue is possible when the result is consumed in the same cycle.
- Accept = in_valid & in_ready. Operands and op are captured at accept; later changes to the inputs are ignored.
- Single-cycle ops (000-101):
  - On accept, result and flags are loaded.
  - Next state is HOLD with out_valid=1. Latency 1 cycle.
- add/sub:
  - sub computes A + ~B + 1.
  - overflow = (A[msb]==B'[msb]) & (sum[msb]!=A[msb]), where B' is the effective second operand.
  - Carry is discarded; wrap-around modulo 2^WIDTH.
- slt:
  - result = {0..., diff[msb] ^ ovf_sub}, a signed compare.
  - overflow flag reports 0.
- sll/srl:
  - On accept, a working register loads A and the counter loads shamt.
  - If shamt==0, go directly to HOLD with result=A (latency 1).
  - Otherwise enter SHIFT and shift by 1 each cycle, decrementing the counter.
  - When the counter reaches 1, that cycle's shift completes, then move to HOLD.
  - Latency = shamt+1 cycles.
  - srl is logical (zero fill). Bits of src_b above SHW are ignored.
- HOLD:
  - result, zero and overflow are stable until out_valid & out_ready.
  - Handshake complete and no new accept: go to IDLE, out_valid=0.
  - Handshake complete with a simultaneous accept: load the new operation. The next state follows the rules above (HOLD or SHIFT).
- out_valid never drops without a handshake, except on reset.
- Reset mid-SHIFT or mid-HOLD aborts the operation. The result is lost and all outputs return to reset values.
- in_valid while in SHIFT is not accepted (in_ready=0). The requester holds the request.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t with the 8 codes above.
  - state enum.
- The ALU decoder and alu_exec both import alu_op_t.
- One sub-module, alu_comb: purely combinational add/sub/and/or/xor/slt, producing a raw result and overflow.
- alu_exec instantiates alu_comb and owns the FSM, shifter and output registers.

Test Plan:
- Reset behaviour: reset_n=0 mid-SHIFT (sll, shamt=20, after 5 cycles) -> out_valid=0, result=0 immediately; after release in_ready=1 in IDLE.
- add/sub: add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, zero=0, 1 cycle. sub 5-5 -> result 0, zero=1, overflow=0.
- slt: A=0xFFFFFFFF (-1), B=1 -> result 1. A=0x80000000, B=0x7FFFFFFF -> result 1. A=3, B=-2 -> result 0.
- Shift latency: sll A=0x1, shamt=31 -> 0x80000000 after exactly 32 cycles. srl A=0x80000000, src_b=0xFFFFFFE4 (shamt 4) -> 0x08000000 after 5 cycles. shamt=0 -> result=A after 1 cycle.
- Backpressure: out_ready=0 for 10 cycles -> result/flags stable, in_ready=0. Raise out_ready with in_valid=1 (and 0xF0 & 0x3C) -> same-cycle handoff, next cycle result 0x30.
- Stream: random ops with random out_ready, checked against a reference model. No lost or duplicated results; order preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encoding and execute-unit state encoding.
// Imported by the ALU decoder and by alu_exec.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_HOLD  = 2'b10
   } alu_state_t;

   function automatic logic is_shift(input alu_op_t op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational add/sub/logic/slt datapath.
// Shift codes are handled by the iterative shifter in alu_exec.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             ovf
);

   logic             use_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             ovf_raw;

   // slt reuses the subtractor; its sign is corrected by the overflow bit
   assign use_sub = (op == ALU_SUB) || (op == ALU_SLT);
   assign b_eff   = use_sub ? ~b : b;
   assign sum     = a + b_eff + WIDTH'(use_sub);
   assign ovf_raw = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      res = a;
      ovf = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            res = sum;
            ovf = ovf_raw;
         end
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_XOR: res = a ^ b;
         ALU_SLT: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
         default: res = a;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Registered ALU execute unit: valid/ready in, valid/ready out,
// single-cycle logic/arith ops and 1-bit-per-cycle iterative shifts.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | no operation in flight
// ST_SHIFT | shift iterating, counter holds remaining steps
// ST_HOLD  | result valid, waiting for the consumer
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_t       state;
   logic [SHW-1:0]   cnt;
   logic             shift_left;
   alu_op_t          op_in;
   logic [SHW-1:0]   shamt_in;
   logic [WIDTH-1:0] comb_res;
   logic             comb_ovf;
   logic [WIDTH-1:0] shifted;
   logic             accept;

   assign op_in    = alu_op_t'(alu_control);
   assign shamt_in = src_b[SHW-1:0];
   assign in_ready = reset_n && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
   assign accept   = in_valid && in_ready;
   // the result register doubles as the shifter working register
   assign shifted  = shift_left ? {result[WIDTH-2:0], 1'b0} : {1'b0, result[WIDTH-1:1]};

   alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
      .op  (op_in),
      .a   (src_a),
      .b   (src_b),
      .res (comb_res),
      .ovf (comb_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         result     <= '0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         cnt        <= '0;
         shift_left <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (accept) begin
                  if (is_shift(op_in)) begin
                     result     <= src_a;
                     overflow   <= 1'b0;
                     cnt        <= shamt_in;
                     shift_left <= (op_in == ALU_SLL);
                     if (shamt_in == '0) begin
                        zero      <= (src_a == '0);
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                     end else begin
                        out_valid <= 1'b0;
                        state     <= ST_SHIFT;
                     end
                  end else begin
                     result    <= comb_res;
                     zero      <= (comb_res == '0);
                     overflow  <= comb_ovf;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                  end
               end else if (state == ST_HOLD && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               result <= shifted;
               cnt    <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  zero      <= (shifted == '0);
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
